// File: rtl/top_fsm.sv
// Byte-pair packing transfer: RAM_IN bytes are packed pairwise into RAM_OUT words.
// Optional macro TOP_FSM_BYTE_SWAP_EN places the odd byte in the high half of each word.
module top_fsm #(
  parameter int WIDTH_WR  = 8,
  parameter int ADDR_WR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ram_in_we,
  input  logic [ADDR_WR_W-1:0]     ram_in_addr_wr,
  input  logic [WIDTH_WR-1:0]      ram_in_data_wr,
  input  logic [ADDR_WR_W-2:0]     ram_out_addr_rd,
  output logic [2*WIDTH_WR-1:0]    ram_out_data_rd,
  input  logic                     opmode_in,
  output logic                     done_out
);

  localparam int DEPTH_IN  = 1 << ADDR_WR_W;
  localparam int DEPTH_OUT = 1 << (ADDR_WR_W - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_EVEN = 2'd1;
  localparam logic [1:0] ST_RD_ODD  = 2'd2;

  localparam logic [ADDR_WR_W-2:0] K_ZERO = {(ADDR_WR_W-1){1'b0}};
  localparam logic [ADDR_WR_W-2:0] K_ONE  = {{(ADDR_WR_W-2){1'b0}}, 1'b1};
  localparam logic [ADDR_WR_W-2:0] K_LAST = {(ADDR_WR_W-1){1'b1}};

  logic [WIDTH_WR-1:0]   ram_in_q  [DEPTH_IN];
  logic [2*WIDTH_WR-1:0] ram_out_q [DEPTH_OUT];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WR_W-2:0]  k_q, k_d;
  logic [WIDTH_WR-1:0]   hi_q, hi_d;
  logic                  done_q, done_d;
  logic                  out_we_s;
  logic [2*WIDTH_WR-1:0] out_wdata_s;
  logic [WIDTH_WR-1:0]   odd_byte_s;

  // Host write port into RAM_IN; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_in_we) begin
      ram_in_q[ram_in_addr_wr] <= ram_in_data_wr;
    end
  end

  // FSM-only write port into RAM_OUT; contents survive reset.
  always_ff @(posedge clk) begin
    if (out_we_s) begin
      ram_out_q[k_q] <= out_wdata_s;
    end
  end

  assign ram_out_data_rd = ram_out_q[ram_out_addr_rd];
  assign done_out        = done_q;

  // Next-state, pair index, high-byte capture and RAM_OUT write generation.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    hi_d       = hi_q;
    done_d     = done_q;
    out_we_s   = 1'b0;
    odd_byte_s = ram_in_q[{k_q, 1'b1}];
`ifdef TOP_FSM_BYTE_SWAP_EN
    out_wdata_s = {odd_byte_s, hi_q};
`else
    out_wdata_s = {hi_q, odd_byte_s};
`endif
    case (state_q)
      ST_IDLE: begin
        if (opmode_in) begin
          state_d = ST_RD_EVEN;
          done_d  = 1'b0;
          k_d     = K_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_EVEN: begin
        hi_d    = ram_in_q[{k_q, 1'b0}];
        state_d = ST_RD_ODD;
      end
      ST_RD_ODD: begin
        out_we_s = 1'b1;
        if (k_q == K_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = ST_RD_EVEN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = K_ZERO;
      end
    endcase
  end

  // Control registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= K_ZERO;
      hi_q    <= {WIDTH_WR{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_top_fsm.sv
// Scoreboard bench for top_fsm: stimulus pushes expected done edges and RAM_OUT words,
// a negedge monitor pops and compares them against the DUT.
module tb_top_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_in_we;
  logic [4:0]  ram_in_addr_wr;
  logic [7:0]  ram_in_data_wr;
  logic [3:0]  ram_out_addr_rd;
  logic [15:0] ram_out_data_rd;
  logic        opmode_in;
  logic        done_out;

  top_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .ram_in_we       (ram_in_we),
    .ram_in_addr_wr  (ram_in_addr_wr),
    .ram_in_data_wr  (ram_in_data_wr),
    .ram_out_addr_rd (ram_out_addr_rd),
    .ram_out_data_rd (ram_out_data_rd),
    .opmode_in       (opmode_in),
    .done_out        (done_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } rd_exp_t;

  int        cyc = 0;
  int        n_checks = 0;
  int        n_pass = 0;
  logic [7:0]  mem [32];
  logic [15:0] exp_out [16];
  bit        model_done = 1'b0;
  bit        rd_pend = 1'b0;
  int        rise_q[$];
  int        fall_q[$];
  rd_exp_t   rd_q[$];
  logic      prev_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pack(input logic [7:0] even_b, input logic [7:0] odd_b);
`ifdef TOP_FSM_BYTE_SWAP_EN
    return {odd_b, even_b};
`else
    return {even_b, odd_b};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares read data and done_out edges against queued expectations.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_pend) begin
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk($sformatf("ram_out[%0d]", e.addr), {16'h0, ram_out_data_rd}, {16'h0, e.data});
      end
    end
    if (prev_done === 1'b0 && done_out === 1'b1) begin
      if (rise_q.size() > 0) chk("done_rise_cycle", cyc, rise_q.pop_front());
      else begin
        n_checks++;
        $display("FAIL unexpected_done_rise: rose at cycle %0d, expected no rise", cyc);
      end
    end
    if (prev_done === 1'b1 && done_out === 1'b0) begin
      if (fall_q.size() > 0) chk("done_fall_cycle", cyc, fall_q.pop_front());
      else begin
        n_checks++;
        $display("FAIL unexpected_done_fall: fell at cycle %0d, expected no fall", cyc);
      end
    end
    prev_done = done_out;
  end

  task automatic wr(input int a, input logic [7:0] d);
    ram_in_we      = 1'b1;
    ram_in_addr_wr = a[4:0];
    ram_in_data_wr = d;
    mem[a]         = d;
    @(posedge clk); #1;
    ram_in_we = 1'b0;
  endtask

  task automatic start_xfer(input bit with_wr, input int a, input logic [7:0] d);
    int e0;
    if (with_wr) begin
      ram_in_we      = 1'b1;
      ram_in_addr_wr = a[4:0];
      ram_in_data_wr = d;
      mem[a]         = d;
    end
    opmode_in = 1'b1;
    e0 = cyc + 1;
    if (model_done) fall_q.push_back(e0);
    rise_q.push_back(e0 + 32);
    model_done = 1'b1;
    for (int k = 0; k < 16; k++) exp_out[k] = pack(mem[2*k], mem[2*k+1]);
    @(posedge clk); #1;
    opmode_in = 1'b0;
    ram_in_we = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done_out === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("done_within_bound", {31'h0, done_out}, 32'h1);
  endtask

  task automatic rd(input int a, input logic [15:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.data = exp;
    rd_q.push_back(e);
    ram_out_addr_rd = a[3:0];
    rd_pend = 1'b1;
    @(posedge clk); #1;
    rd_pend = 1'b0;
  endtask

  task automatic rd_all();
    for (int k = 0; k < 16; k++) rd(k, exp_out[k]);
  endtask

  initial begin
    rst = 1'b1;
    ram_in_we = 1'b0;
    ram_in_addr_wr = 5'd0;
    ram_in_data_wr = 8'd0;
    ram_out_addr_rd = 4'd0;
    opmode_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_done", {31'h0, done_out}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pattern A
    for (int i = 0; i < 32; i++) wr(i, 8'(((i % 2) << 7) + i));
    start_xfer(1'b0, 0, 8'h00);
    wait_done();
`ifdef TOP_FSM_BYTE_SWAP_EN
    rd(0, 16'h8100); rd(1, 16'h8302); rd(15, 16'h9F1E);
`else
    rd(0, 16'h0081); rd(1, 16'h0283); rd(15, 16'h1E9F);
`endif
    rd_all();

    // Pattern B, refilled while done_out is high
    for (int i = 0; i < 32; i++) wr(i, 8'(((i % 2) << 7) + i + 1));
    chk("done_held_during_refill", {31'h0, done_out}, 32'h1);
    start_xfer(1'b0, 0, 8'h00);
    wait_done();
`ifdef TOP_FSM_BYTE_SWAP_EN
    rd(0, 16'h8201); rd(15, 16'hA01F);
`else
    rd(0, 16'h0182); rd(15, 16'h1FA0);
`endif
    rd_all();

    // Second pulse at cycle 10 of a running transfer must be ignored
    start_xfer(1'b0, 0, 8'h00);
    repeat (9) @(posedge clk);
    #1;
    opmode_in = 1'b1;
    @(posedge clk); #1;
    opmode_in = 1'b0;
    wait_done();

    // Reset at cycle 15 of a transfer, then a clean restart
    start_xfer(1'b0, 0, 8'h00);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    rise_q.delete();
    model_done = 1'b0;
    #1;
    chk("midreset_done", {31'h0, done_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset_done", {31'h0, done_out}, 32'h0);
    start_xfer(1'b0, 0, 8'h00);
    wait_done();
    rd_all();

    // Random fills; the final write coincides with the start pulse
    for (int t = 0; t < 3; t++) begin
      int a;
      for (int i = 0; i < 32; i++) wr(i, 8'($urandom));
      a = $urandom_range(0, 31);
      start_xfer(1'b1, a, 8'($urandom));
      wait_done();
      rd_all();
    end

    repeat (2) @(posedge clk);
    #1;
    chk("pending_done_rises", rise_q.size(), 32'h0);
    chk("pending_done_falls", fall_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
